keypad_decoder: RTL
===================

Name: keypad_decoder

Overview:
- Input side of the alarm clock display path. Takes ASCII key codes from the keypad interface and decodes digits 0x30-0x39 to BCD.
- Shifts digits into a 4-digit entry buffer that feeds the display driver's key input.
- Issues one-cycle load strobes for the alarm register ('*') and the current-time register ('#').
- Abandons an entry after a programmable number of one-second ticks with no key activity.

Parameters:
TIMEOUT_TICKS, 10, one_second ticks without a key before the entry is abandoned (legal range 1-15)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
key_ascii  input  8  ASCII key code; sampled only when key_valid=1
key_valid  input  1  one-cycle strobe, key_ascii valid
one_second  input  1  one-cycle tick from the seconds prescaler
clear_buffer  input  1  synchronous abort of entry, buffer to 0
key  output  4  BCD of the last accepted digit
key_buffer  output  16  four BCD digits; [15:12] oldest, [3:0] newest
show_new_time  output  1  high while an entry is in progress (ENTRY state)
load_new_a  output  1  one-cycle strobe: load key_buffer into the alarm register
load_new_c  output  1  one-cycle strobe: load key_buffer into the current time
key_error  output  1  one-cycle strobe: illegal code or premature load

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, key_buffer=16'h0000, digit_count=0, timer=0, state=IDLE.
- All outputs are registered. Response appears on the clock edge that samples key_valid, i.e. visible 1 cycle after the strobe.
- Decode:
  - 8'h30-8'h39 -> digit 0-9.
  - 8'h2A -> STAR.
  - 8'h23 -> HASH.
  - Anything else -> ILLEGAL.
- FSM states: IDLE, ENTRY.
- IDLE:
  - digit: key_buffer<={key_buffer[11:0],d}, key<=d, digit_count<=1, timer<=0, go ENTRY.
  - STAR, HASH or ILLEGAL: key_error pulse, stay IDLE, buffer unchanged.
- ENTRY:
  - digit: shift as above; digit_count<=min(count+1,4) (saturates at 4); timer<=0. A 5th and later digit keeps shifting and drops the oldest digit.
  - STAR with digit_count==4: load_new_a pulse, go IDLE, buffer held.
  - HASH with digit_count==4: load_new_c pulse, go IDLE, buffer held.
  - STAR or HASH with digit_count<4: key_error pulse, stay ENTRY, timer<=0.
  - ILLEGAL: key_error pulse, stay ENTRY, timer unchanged.
  - one_second tick with no key_valid: timer<=timer+1. When timer reaches TIMEOUT_TICKS: go IDLE, key_buffer<=0, key<=0, digit_count<=0. No strobe is issued on timeout.
- show_new_time = (state==ENTRY), registered.
- Priority, highest first: reset_n, clear_buffer, key_valid, one_second.
  - clear_buffer forces IDLE, clears the buffer, key, count and timer, and suppresses any strobe in the same cycle.
  - key_valid together with one_second in the same cycle: the key is processed and the tick is ignored, so the timer does not advance.
- Strobes are mutually exclusive and last exactly one cycle. All strobes are 0 in IDLE with no key.
- Reset asserted mid-entry: immediate return to the reset values, independent of the clock.
- Timer is 4 bits and never wraps: it is cleared on timeout.

Optional Feature:
- Macro: KEYPAD_RANGE_CHECK_EN.
- Defined: a STAR or HASH with digit_count==4 also requires key_buffer to hold a legal HH:MM, i.e. key_buffer[15:8] BCD <= 23 and key_buffer[7:4] <= 5.
  - Failure gives a key_error pulse and no load strobe; the block stays in ENTRY with timer<=0.
- Not defined: no range check; any 4 digits load.

Test Plan:
- Reset: hold reset_n=0, release -> all outputs 0, show_new_time=0; keys ignored during reset.
- Keys '1','2','3','4' then '#' -> key_buffer=16'h1234, key=4, show_new_time=1 after the first digit; load_new_c high exactly 1 cycle after '#'; then IDLE with buffer 16'h1234.
- Keys '0','7' then '*' -> key_error pulse, load_new_a stays 0, still ENTRY. Then '3','0','*' -> key_buffer=16'h0730, load_new_a pulse.
- Key 8'h41 ('A') in IDLE -> key_error pulse, buffer unchanged. Then '5' followed by 10 one_second ticks with no key -> on the 10th tick: IDLE, key_buffer=0, no strobes.
- Key '9' with one_second in the same cycle, then 9 more ticks -> still ENTRY (timer=9); 10th tick -> timeout. clear_buffer mid-entry -> IDLE, buffer 0 next cycle.
- With KEYPAD_RANGE_CHECK_EN defined, keys '2','5','0','0','#' -> key_error, no load_new_c. Without the macro, the same sequence -> load_new_c with key_buffer=16'h2500.

Source files
------------

// File: rtl/keypad_decoder.sv
// Keypad entry decoder for the alarm clock: ASCII digits feed a 4-digit BCD buffer, '*'/'#' load it.
// Optional macro KEYPAD_RANGE_CHECK_EN rejects loads whose buffer is not a legal HH:MM.
module keypad_decoder #(
   parameter int unsigned TIMEOUT_TICKS = 10
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  key_ascii,
   input  logic        key_valid,
   input  logic        one_second,
   input  logic        clear_buffer,
   output logic [3:0]  key,
   output logic [15:0] key_buffer,
   output logic        show_new_time,
   output logic        load_new_a,
   output logic        load_new_c,
   output logic        key_error
);

   // Handshake: key_valid is a one-cycle strobe with no ready; a key is consumed on the
   // edge that samples it and every response is visible on the registered outputs one cycle later.

   typedef enum logic {
      IDLE  = 1'b0,
      ENTRY = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      K_DIGIT   = 2'd0,
      K_STAR    = 2'd1,
      K_HASH    = 2'd2,
      K_ILLEGAL = 2'd3
   } key_kind_e;

   localparam logic [3:0] TIMEOUT_VAL = 4'(TIMEOUT_TICKS);

   state_e      state_q, state_d;
   logic [3:0]  key_q, key_d;
   logic [15:0] buf_q, buf_d;
   logic [2:0]  count_q, count_d;
   logic [3:0]  timer_q, timer_d;
   logic        show_q, show_d;
   logic        load_a_q, load_a_d;
   logic        load_c_q, load_c_d;
   logic        error_q, error_d;

   key_kind_e   kind;
   logic [3:0]  digit;
   logic        count_full;
   logic        range_ok;
   logic        load_ok;
   logic [3:0]  timer_inc;
   logic        timeout;

   always_comb begin
      digit = key_ascii[3:0];
      if (key_ascii >= 8'h30 && key_ascii <= 8'h39) begin
         kind = K_DIGIT;
      end else if (key_ascii == 8'h2A) begin
         kind = K_STAR;
      end else if (key_ascii == 8'h23) begin
         kind = K_HASH;
      end else begin
         kind = K_ILLEGAL;
      end
   end

`ifdef KEYPAD_RANGE_CHECK_EN
   // Digits are always 0-9, so hours <= 23 reduces to tens < 2, or tens == 2 with units <= 3.
   assign range_ok = ((buf_q[15:12] < 4'd2) || (buf_q[15:12] == 4'd2 && buf_q[11:8] <= 4'd3))
                     && (buf_q[7:4] <= 4'd5);
`else
   assign range_ok = 1'b1;
`endif

   assign count_full = (count_q == 3'd4);
   assign load_ok    = (state_q == ENTRY) && count_full && range_ok;
   assign timer_inc  = timer_q + 4'd1;
   assign timeout    = (timer_inc == TIMEOUT_VAL);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         key_q    <= 4'd0;
         buf_q    <= 16'h0000;
         count_q  <= 3'd0;
         timer_q  <= 4'd0;
         show_q   <= 1'b0;
         load_a_q <= 1'b0;
         load_c_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         key_q    <= key_d;
         buf_q    <= buf_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         show_q   <= show_d;
         load_a_q <= load_a_d;
         load_c_q <= load_c_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear_buffer) begin
         state_d = IDLE;
      end else if (key_valid) begin
         case (state_q)
            IDLE: begin
               if (kind == K_DIGIT) state_d = ENTRY;
            end
            ENTRY: begin
               if ((kind == K_STAR || kind == K_HASH) && load_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (one_second && state_q == ENTRY && timeout) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      key_d    = key_q;
      buf_d    = buf_q;
      count_d  = count_q;
      timer_d  = timer_q;
      load_a_d = 1'b0;
      load_c_d = 1'b0;
      error_d  = 1'b0;
      if (clear_buffer) begin
         key_d   = 4'd0;
         buf_d   = 16'h0000;
         count_d = 3'd0;
         timer_d = 4'd0;
      end else if (key_valid) begin
         case (kind)
            K_DIGIT: begin
               buf_d   = {buf_q[11:0], digit};
               key_d   = digit;
               timer_d = 4'd0;
               if (state_q == IDLE) begin
                  count_d = 3'd1;
               end else if (!count_full) begin
                  count_d = count_q + 3'd1;
               end
            end
            K_STAR, K_HASH: begin
               if (load_ok) begin
                  load_a_d = (kind == K_STAR);
                  load_c_d = (kind == K_HASH);
               end else begin
                  error_d = 1'b1;
                  if (state_q == ENTRY) timer_d = 4'd0;
               end
            end
            default: begin
               error_d = 1'b1;
            end
         endcase
      end else if (one_second && state_q == ENTRY) begin
         if (timeout) begin
            key_d   = 4'd0;
            buf_d   = 16'h0000;
            count_d = 3'd0;
            timer_d = 4'd0;
         end else begin
            timer_d = timer_inc;
         end
      end
      show_d = (state_d == ENTRY);
   end

   assign key           = key_q;
   assign key_buffer    = buf_q;
   assign show_new_time = show_q;
   assign load_new_a    = load_a_q;
   assign load_new_c    = load_c_q;
   assign key_error     = error_q;

endmodule
